// File: rtl/serial_paralelo_rx_if.sv
// Bus bundle for the serial_paralelo_rx deserializer: serial lane in, word/valid/active out.
// SPR_WORD_COUNT_EN adds the word_count output to the bundle.
interface serial_paralelo_rx_if;
  logic        data_serial;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
`ifdef SPR_WORD_COUNT_EN
  logic [15:0] word_count;

  modport master (output data_serial, input data_out, input valid_out, input active,
                  input word_count);
  modport slave  (input data_serial, output data_out, output valid_out, output active,
                  output word_count);
`else
  modport master (output data_serial, input data_out, input valid_out, input active);
  modport slave  (input data_serial, output data_out, output valid_out, output active);
`endif
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: aligns on COM_SYMBOL, then packs data bytes into 32-bit words.
// Optional SPR_WORD_COUNT_EN adds a wrapping 16-bit count of delivered words.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned N_COM      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  bus
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [3:0]  com_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic [7:0]  nxt;
  logic        byte_done;
  logic        is_com;

  assign nxt       = {shift[6:0], bus.data_serial};
  assign byte_done = (bit_cnt == 3'd7);
  assign is_com    = (nxt == COM_SYMBOL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= SEARCH;
      shift         <= '0;
      bit_cnt       <= '0;
      com_cnt       <= '0;
      byte_idx      <= '0;
      partial       <= '0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.active    <= 1'b0;
    end else begin
      shift         <= nxt;
      bus.valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          bit_cnt <= '0;
          if (is_com) begin
            com_cnt <= 4'd1;
            if (N_COM == 1) begin
              state      <= ACTIVE;
              bus.active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (is_com) begin
              com_cnt <= com_cnt + 4'd1;
              if (32'(com_cnt) + 32'd1 == N_COM) begin
                state      <= ACTIVE;
                bus.active <= 1'b1;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          // COMs in ACTIVE are idle fill: the partial word is left untouched
          if (byte_done && !is_com) begin
            case (byte_idx)
              2'd0: partial[23:16] <= nxt;
              2'd1: partial[15:8]  <= nxt;
              2'd2: partial[7:0]   <= nxt;
              default: begin
                bus.data_out  <= {partial, nxt};
                bus.valid_out <= 1'b1;
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        default: begin
          state   <= SEARCH;
          bit_cnt <= '0;
          com_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SPR_WORD_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.word_count <= '0;
    end else if (state == ACTIVE && byte_done && !is_com && byte_idx == 2'd3) begin
      bus.word_count <= bus.word_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Receive-side deserializer directly upstream of the recirculator.
- Takes a 1-bit serial lane (one bit per clk, MSB first) and finds byte alignment on the COM symbol.
- Asserts active after N_COM consecutive aligned COMs.
- Packs non-COM data bytes into 32-bit words, delivered with a one-cycle valid pulse; active is the recirculator's mode-select input.

Parameters:
COM_SYMBOL  8'hBC  alignment/idle control byte
N_COM       4      consecutive aligned COMs required to enter ACTIVE (range 1..15)

Ports:
clk          input   1   bit clock; all logic on posedge
reset        input   1   synchronous, active-low; clock clk
data_serial  input   1   serial bit, sampled every posedge, MSB of each byte first
data_out     output  32  assembled word; first received byte in [31:24], last in [7:0]
valid_out    output  1   one-cycle pulse, data_out holds a new word
active       output  1   1 while in ACTIVE state (link aligned)

Behaviour:
- Reset (reset==0 at posedge): state=SEARCH, shift reg=0, bit_cnt=0, com_cnt=0, byte_idx=0; data_out=0, valid_out=0, active=0. Reset overrides everything, including mid-word or mid-alignment.
- Define nxt = {shift[6:0], data_serial}; shift <= nxt every cycle when not in reset.
- "Byte complete" means bit_cnt==7 in ALIGN/ACTIVE; bit_cnt wraps 7->0. The completed byte is nxt.
- SEARCH:
  - bit_cnt is don't-care and is forced to 0 on entry.
  - If nxt==COM_SYMBOL: go to ALIGN, bit_cnt<=0 (next bit is bit 7 of the next byte), com_cnt<=1.
  - If N_COM==1, go straight to ACTIVE instead.
- ALIGN:
  - bit_cnt increments each cycle.
  - At byte complete with byte==COM: com_cnt++. If com_cnt+1==N_COM, go to ACTIVE.
  - At byte complete with byte!=COM: go to SEARCH, com_cnt<=0. No sliding re-check of that byte.
- ACTIVE:
  - active=1 from the cycle after the transition (registered).
  - At byte complete with byte==COM: idle; discard the byte, keep the partial word and byte_idx unchanged.
  - At byte complete with byte!=COM: write the byte into slot byte_idx (0->[31:24] ... 3->[7:0]) and increment byte_idx.
  - When byte_idx==3 and a data byte completes: data_out <= full word (including this byte) on that same edge, valid_out<=1 for exactly that one cycle, byte_idx<=0.
- Latency: valid_out rises on the edge that samples the last bit of the 4th data byte, so the word is visible the following cycle.
- valid_out is 0 in every other cycle. data_out holds its last value between pulses.
- ACTIVE is left only via reset; there is no loss-of-sync detection in the base build.
- Maximum throughput is one word per 32 clks; consecutive pulses are therefore at least 32 cycles apart.

Optional Feature:
- Macro: SPR_WORD_COUNT_EN.
- Defined:
  - Adds output port word_count [15:0].
  - word_count increments on every valid_out pulse and wraps 16'hFFFF->0.
  - Reset value is 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random data_serial -> data_out=0, valid_out=0, active=0 throughout, state SEARCH.
- Alignment: 3 random bits, then 4x 8'hBC (N_COM=4) -> active rises the cycle after the 32nd bit of the BC run; valid_out stays 0.
- Word pack: after alignment send 8'h12,8'h34,8'h56,8'h78 -> single valid_out pulse with data_out=32'h12345678, active still 1.
- Idle insertion: send 8'hAA, 8'hBC, 8'hBB, 8'hBC, 8'hBC, 8'hCC, 8'hDD -> one pulse, data_out=32'hAABBCCDD, no pulse during the COMs.
- Broken alignment: BC, BC, 8'h00, then 4x BC -> active stays 0 through the 8'h00, then rises after the final 4 BC bytes.
- Reset mid-word: aligned, send 8'h11,8'h22, pull reset low 1 cycle -> active=0, byte_idx cleared; re-align plus 4 data bytes 8'hA1..8'hA4 -> data_out=32'hA1A2A3A4.
- With SPR_WORD_COUNT_EN: 3 words -> word_count=3; reset -> 0.
